// File: rtl/ctrl_fsm_wait_if.sv
// Control/status bundle between the ctrl_fsm_wait sequencer (master) and the
// datapath/memory side (slave).
interface ctrl_fsm_wait_if;
   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] cond;
   logic       Z, N, V;
   logic       mem_ready;
   logic       resume;

   logic [1:0] vsel;
   logic [2:0] nsel;
   logic       loada, loadb, asel, bsel, loadc, loads, write;
   logic [1:0] mem_cmd;
   logic       load_pc, reset_pc, pc_sel, addr_sel, load_ir, load_addr;
   logic       halted, err;
   logic [4:0] state;

   modport master (
      input  opcode, op, cond, Z, N, V, mem_ready, resume,
      output vsel, nsel, loada, loadb, asel, bsel, loadc, loads, write,
      output mem_cmd, load_pc, reset_pc, pc_sel, addr_sel, load_ir, load_addr,
      output halted, err, state
   );

   modport slave (
      output opcode, op, cond, Z, N, V, mem_ready, resume,
      input  vsel, nsel, loada, loadb, asel, bsel, loadc, loads, write,
      input  mem_cmd, load_pc, reset_pc, pc_sel, addr_sel, load_ir, load_addr,
      input  halted, err, state
   );
endinterface

// File: rtl/ctrl_fsm_wait.sv
// Moore instruction sequencer with bounded memory waits, HALT and sticky ERR.
// Define CTRL_FSM_BRANCH_EN to build the BR/BTK branch path.
module ctrl_fsm_wait #(
   parameter int WAIT_LIMIT = 15,
   parameter int WAIT_W     = 4
) (
   input logic             clk,
   input logic             reset,
   ctrl_fsm_wait_if.master bus
);

   typedef enum logic [4:0] {
      RST  = 5'd0,  IF1  = 5'd1,  IF2  = 5'd2,  UPC  = 5'd3,
      DEC  = 5'd4,  LDA  = 5'd5,  LDB  = 5'd6,  EXE  = 5'd7,
      EXA  = 5'd8,  WB   = 5'd9,  MOVI = 5'd10, ACAL = 5'd11,
      LADR = 5'd12, MRD  = 5'd13, LWB  = 5'd14, STB  = 5'd15,
      STP  = 5'd16, MWR  = 5'd17, HALT = 5'd18,
`ifdef CTRL_FSM_BRANCH_EN
      BR   = 5'd20, BTK  = 5'd21,
`endif
      ERR  = 5'd19
   } state_t;

   typedef struct packed {
      logic [1:0] vsel;
      logic [2:0] nsel;
      logic       loada, loadb, asel, bsel, loadc, loads, write;
      logic [1:0] mem_cmd;
      logic       load_pc, reset_pc, addr_sel, load_ir, load_addr;
      logic       halted, err;
   } ctl_t;

   localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   ctl_t              ctl_q;
   logic              armed_q;

   function automatic ctl_t decode(state_t s);
      ctl_t c;
      c = '0;
      case (s)
         RST:  begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
         IF1:  begin c.mem_cmd = 2'b01; c.addr_sel = 1'b1; end
         IF2:  begin c.mem_cmd = 2'b01; c.addr_sel = 1'b1; c.load_ir = 1'b1; end
         UPC:  c.load_pc = 1'b1;
         LDA:  begin c.nsel = 3'b001; c.loada = 1'b1; end
         LDB:  begin c.nsel = 3'b100; c.loadb = 1'b1; end
         EXE:  begin c.loadc = 1'b1; c.loads = 1'b1; end
         EXA:  begin c.loadc = 1'b1; c.loads = 1'b1; c.asel = 1'b1; end
         WB:   begin c.nsel = 3'b010; c.write = 1'b1; end
         MOVI: begin c.nsel = 3'b001; c.vsel = 2'b10; c.write = 1'b1; end
         ACAL: begin c.loadc = 1'b1; c.bsel = 1'b1; end
         LADR: c.load_addr = 1'b1;
         MRD:  c.mem_cmd = 2'b01;
         LWB:  begin c.mem_cmd = 2'b01; c.nsel = 3'b010; c.vsel = 2'b11; c.write = 1'b1; end
         STB:  begin c.nsel = 3'b010; c.loadb = 1'b1; end
         STP:  begin c.loadc = 1'b1; c.asel = 1'b1; end
         MWR:  c.mem_cmd = 2'b10;
         HALT: c.halted = 1'b1;
         ERR:  c.err = 1'b1;
`ifdef CTRL_FSM_BRANCH_EN
         BTK:  c.load_pc = 1'b1;
`endif
         default: ;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         RST:  state_d = armed_q ? IF1 : RST;
         IF1:  if (bus.mem_ready) state_d = IF2;
         IF2:  state_d = UPC;
         UPC:  state_d = DEC;
         DEC: begin
            case (bus.opcode)
               3'b101, 3'b011, 3'b100: state_d = LDA;
               3'b110: state_d = (bus.op == 2'b10) ? MOVI :
                                 (bus.op == 2'b00) ? LDB : ERR;
               3'b111: state_d = HALT;
`ifdef CTRL_FSM_BRANCH_EN
               3'b001: state_d = BR;
`endif
               default: state_d = ERR;
            endcase
         end
         LDA:  state_d = (bus.opcode == 3'b101) ? LDB : ACAL;
         LDB:  state_d = (bus.opcode == 3'b110) ? EXA : EXE;
         EXE:  state_d = (bus.op == 2'b01) ? IF1 : WB;
         EXA:  state_d = WB;
         WB:   state_d = IF1;
         MOVI: state_d = IF1;
         ACAL: state_d = LADR;
         LADR: state_d = (bus.opcode == 3'b011) ? MRD : STB;
         MRD:  if (bus.mem_ready) state_d = LWB;
         LWB:  state_d = IF1;
         STB:  state_d = STP;
         STP:  state_d = MWR;
         MWR:  if (bus.mem_ready) state_d = IF1;
         HALT: if (bus.resume) state_d = IF1;
         ERR:  state_d = ERR;
`ifdef CTRL_FSM_BRANCH_EN
         BR: begin
            case (bus.cond)
               3'b000:  state_d = BTK;
               3'b001:  state_d = bus.Z ? BTK : IF1;
               3'b010:  state_d = !bus.Z ? BTK : IF1;
               3'b011:  state_d = (bus.N != bus.V) ? BTK : IF1;
               3'b100:  state_d = ((bus.N != bus.V) || bus.Z) ? BTK : IF1;
               default: state_d = ERR;
            endcase
         end
         BTK:  state_d = IF1;
`endif
         default: state_d = ERR;
      endcase
      // Counter only runs while parked in a wait state; any other cycle clears it.
      if ((state_q inside {IF1, MRD, MWR}) && !bus.mem_ready) begin
         if (cnt_q == LIMIT) state_d = ERR;
         else                cnt_d   = cnt_q + 1'b1;
      end
   end

   // Outputs are registered from the next state so they always match state_q.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RST;
         cnt_q   <= '0;
         ctl_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctl_q   <= decode(state_d);
         armed_q <= 1'b1;
      end
   end

`ifdef CTRL_FSM_BRANCH_EN
   logic pc_sel_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_sel_q <= 1'b0;
      else        pc_sel_q <= (state_d == BTK);
   end
   assign bus.pc_sel = pc_sel_q;
`else
   logic unused_br;
   assign unused_br  = ^{bus.cond, bus.Z, bus.N, bus.V};
   assign bus.pc_sel = 1'b0;
`endif

   assign bus.vsel      = ctl_q.vsel;
   assign bus.nsel      = ctl_q.nsel;
   assign bus.loada     = ctl_q.loada;
   assign bus.loadb     = ctl_q.loadb;
   assign bus.asel      = ctl_q.asel;
   assign bus.bsel      = ctl_q.bsel;
   assign bus.loadc     = ctl_q.loadc;
   assign bus.loads     = ctl_q.loads;
   assign bus.write     = ctl_q.write;
   assign bus.mem_cmd   = ctl_q.mem_cmd;
   assign bus.load_pc   = ctl_q.load_pc;
   assign bus.reset_pc  = ctl_q.reset_pc;
   assign bus.addr_sel  = ctl_q.addr_sel;
   assign bus.load_ir   = ctl_q.load_ir;
   assign bus.load_addr = ctl_q.load_addr;
   assign bus.halted    = ctl_q.halted;
   assign bus.err       = ctl_q.err;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_ctrl_fsm_wait.sv
// Bench for ctrl_fsm_wait: an instruction-level model expands each instruction
// into its expected per-cycle phases, which are replayed against the DUT.
module tb_ctrl_fsm_wait;
   localparam int LIMIT = 15;

   logic clk, reset;
   ctrl_fsm_wait_if bus ();

   ctrl_fsm_wait #(.WAIT_LIMIT(LIMIT), .WAIT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum {P_RST, P_IF1, P_IF2, P_UPC, P_DEC, P_LDA, P_LDB, P_EXE, P_EXEA,
                 P_WB, P_MOVI, P_ACAL, P_LADR, P_MRD, P_LWB, P_STB, P_STP, P_MWR,
                 P_HALT, P_ERR, P_BR, P_BTK} ph_t;

   typedef struct packed {
      logic [1:0] vsel;
      logic [2:0] nsel;
      logic       loada, loadb, asel, bsel, loadc, loads, write;
      logic [1:0] mem_cmd;
      logic       load_pc, reset_pc, pc_sel, addr_sel, load_ir, load_addr;
      logic       halted, err;
   } ctl_t;

   typedef struct {
      ph_t        ph;
      logic       rdy, res;
      logic [2:0] opc;
      logic [1:0] op;
      logic [2:0] cond;
      logic       z, n, v;
   } ent_t;

   ent_t       q[$];
   int         checks = 0;
   int         failures = 0;
   logic [2:0] c_opc, c_cond;
   logic [1:0] c_op;
   logic       c_z, c_n, c_v;

   // Output table per phase, straight from the state/output list.
   function automatic ctl_t exp_of(ph_t p);
      ctl_t c;
      c = '0;
      case (p)
         P_RST:  begin c.reset_pc = 1; c.load_pc = 1; end
         P_IF1:  begin c.mem_cmd = 2'b01; c.addr_sel = 1; end
         P_IF2:  begin c.mem_cmd = 2'b01; c.addr_sel = 1; c.load_ir = 1; end
         P_UPC:  c.load_pc = 1;
         P_LDA:  begin c.nsel = 3'b001; c.loada = 1; end
         P_LDB:  begin c.nsel = 3'b100; c.loadb = 1; end
         P_EXE:  begin c.loadc = 1; c.loads = 1; end
         P_EXEA: begin c.loadc = 1; c.loads = 1; c.asel = 1; end
         P_WB:   begin c.nsel = 3'b010; c.write = 1; c.vsel = 2'b00; end
         P_MOVI: begin c.nsel = 3'b001; c.vsel = 2'b10; c.write = 1; end
         P_ACAL: begin c.loadc = 1; c.bsel = 1; end
         P_LADR: c.load_addr = 1;
         P_MRD:  c.mem_cmd = 2'b01;
         P_LWB:  begin c.mem_cmd = 2'b01; c.nsel = 3'b010; c.vsel = 2'b11; c.write = 1; end
         P_STB:  begin c.nsel = 3'b010; c.loadb = 1; end
         P_STP:  begin c.loadc = 1; c.asel = 1; end
         P_MWR:  c.mem_cmd = 2'b10;
         P_HALT: c.halted = 1;
         P_ERR:  c.err = 1;
         P_BTK:  begin c.pc_sel = 1; c.load_pc = 1; end
         default: ;
      endcase
      return c;
   endfunction

   function automatic ctl_t actual();
      ctl_t c;
      c.vsel = bus.vsel;   c.nsel = bus.nsel;   c.loada = bus.loada; c.loadb = bus.loadb;
      c.asel = bus.asel;   c.bsel = bus.bsel;   c.loadc = bus.loadc; c.loads = bus.loads;
      c.write = bus.write; c.mem_cmd = bus.mem_cmd; c.load_pc = bus.load_pc;
      c.reset_pc = bus.reset_pc; c.pc_sel = bus.pc_sel; c.addr_sel = bus.addr_sel;
      c.load_ir = bus.load_ir; c.load_addr = bus.load_addr; c.halted = bus.halted;
      c.err = bus.err;
      return c;
   endfunction

   function automatic void push_x(ph_t p, logic rdy, logic res);
      ent_t e;
      e.ph = p; e.rdy = rdy; e.res = res; e.opc = c_opc; e.op = c_op;
      e.cond = c_cond; e.z = c_z; e.n = c_n; e.v = c_v;
      q.push_back(e);
   endfunction

   // Inputs that the phase must ignore are randomized.
   function automatic void push(ph_t p);
      push_x(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endfunction

   function automatic void push_err();
      repeat (3) push(P_ERR);
   endfunction

   // w idle cycles then ready; a cycle whose wait count already equals LIMIT
   // with ready low ends in ERR.
   function automatic bit wait_ph(ph_t p, int w);
      for (int k = 0; k <= LIMIT; k++) begin
         if (k < w) push_x(p, 1'b0, 1'($urandom_range(0, 1)));
         else begin
            push_x(p, 1'b1, 1'($urandom_range(0, 1)));
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   // Expands one instruction into expected phases; returns 1 if it ends in ERR.
   function automatic bit gen(logic [2:0] opc, logic [1:0] op, logic [2:0] cond,
                              logic z, logic n, logic v, int w_if, int w_mem, int h);
      bit taken;
      c_opc = opc; c_op = op; c_cond = cond; c_z = z; c_n = n; c_v = v;
      if (!wait_ph(P_IF1, w_if)) begin push_err(); return 1'b1; end
      push(P_IF2); push(P_UPC); push(P_DEC);
      case (opc)
         3'b101: begin
            push(P_LDA); push(P_LDB); push(P_EXE);
            if (op != 2'b01) push(P_WB);
         end
         3'b110: begin
            if (op == 2'b10) push(P_MOVI);
            else if (op == 2'b00) begin push(P_LDB); push(P_EXEA); push(P_WB); end
            else begin push_err(); return 1'b1; end
         end
         3'b011: begin
            push(P_LDA); push(P_ACAL); push(P_LADR);
            if (!wait_ph(P_MRD, w_mem)) begin push_err(); return 1'b1; end
            push(P_LWB);
         end
         3'b100: begin
            push(P_LDA); push(P_ACAL); push(P_LADR); push(P_STB); push(P_STP);
            if (!wait_ph(P_MWR, w_mem)) begin push_err(); return 1'b1; end
         end
         3'b111: begin
            for (int i = 0; i < h; i++) push_x(P_HALT, 1'($urandom_range(0, 1)), 1'b0);
            push_x(P_HALT, 1'($urandom_range(0, 1)), 1'b1);
         end
`ifdef CTRL_FSM_BRANCH_EN
         3'b001: begin
            push(P_BR);
            if (cond > 3'd4) begin push_err(); return 1'b1; end
            taken = (cond == 3'd0) || (cond == 3'd1 && z) || (cond == 3'd2 && !z) ||
                    (cond == 3'd3 && (n != v)) || (cond == 3'd4 && ((n != v) || z));
            if (taken) push(P_BTK);
         end
`endif
         default: begin push_err(); return 1'b1; end
      endcase
      return 1'b0;
   endfunction

   task automatic run();
      ent_t e;
      ctl_t a, x;
      while (q.size() > 0) begin
         e = q.pop_front();
         bus.opcode = e.opc; bus.op = e.op; bus.cond = e.cond;
         bus.Z = e.z; bus.N = e.n; bus.V = e.v;
         bus.mem_ready = e.rdy; bus.resume = e.res;
         a = actual(); x = exp_of(e.ph);
         checks++;
         if (a !== x) begin
            failures++;
            $display("FAIL phase %s: got %h expected %h", e.ph.name(), a, x);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      checks++;
      if (actual() !== ctl_t'(0)) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0", actual());
      end
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (actual() !== ctl_t'(0)) begin
         failures++;
         $display("FAIL reset_held: got %h expected 0", actual());
      end
      reset = 1'b1;
      @(posedge clk); #1;
      push(P_RST);
   endtask

   task automatic exec(logic [2:0] opc, logic [1:0] op, logic [2:0] cond,
                       logic z, logic n, logic v, int w_if, int w_mem, int h);
      bit e;
      e = gen(opc, op, cond, z, n, v, w_if, w_mem, h);
      run();
      if (e) begin do_reset(); run(); end
   endtask

   task automatic test_reset();
      do_reset();
      run();
   endtask

   task automatic test_alu();
      exec(3'b101, 2'b00, 3'b0, 0, 0, 0, 0, 0, 0);
      exec(3'b101, 2'b01, 3'b0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_mov();
      exec(3'b110, 2'b10, 3'b0, 0, 0, 0, 0, 0, 0);
      exec(3'b110, 2'b00, 3'b0, 0, 0, 0, 2, 0, 0);
   endtask

   task automatic test_mem();
      exec(3'b011, 2'b00, 3'b0, 0, 0, 0, 0, 5, 0);
      exec(3'b100, 2'b11, 3'b0, 0, 0, 0, 2, 3, 0);
   endtask

   task automatic test_branch();
      exec(3'b001, 2'b00, 3'b001, 1, 0, 0, 0, 0, 0);
      exec(3'b001, 2'b00, 3'b001, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_halt();
      exec(3'b111, 2'b00, 3'b0, 0, 0, 0, 0, 0, 10);
   endtask

   task automatic test_wait_limit();
      exec(3'b101, 2'b00, 3'b0, 0, 0, 0, LIMIT, 0, 0);
      exec(3'b101, 2'b00, 3'b0, 0, 0, 0, LIMIT + 1, 0, 0);
      exec(3'b011, 2'b00, 3'b0, 0, 0, 0, 0, LIMIT + 1, 0);
   endtask

   task automatic test_reset_mid_mwr();
      bit ok;
      c_opc = 3'b100; c_op = 2'b00; c_cond = 3'b0; c_z = 0; c_n = 0; c_v = 0;
      ok = wait_ph(P_IF1, 0);
      push(P_IF2); push(P_UPC); push(P_DEC); push(P_LDA); push(P_ACAL);
      push(P_LADR); push(P_STB); push(P_STP);
      push_x(P_MWR, 1'b0, 1'b0); push_x(P_MWR, 1'b0, 1'b0);
      run();
      checks++;
      if (!ok || bus.mem_cmd !== 2'b10) begin
         failures++;
         $display("FAIL mwr_before_reset: mem_cmd=%b expected 10", bus.mem_cmd);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (bus.mem_cmd !== 2'b00 || actual() !== ctl_t'(0)) begin
         failures++;
         $display("FAIL mwr_abort: mem_cmd=%b outputs=%h expected 00/0", bus.mem_cmd, actual());
      end
      do_reset();
      run();
      exec(3'b101, 2'b00, 3'b0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         exec(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? LIMIT + 1 : int'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0) ? LIMIT + 1 : int'($urandom_range(0, 5)),
              int'($urandom_range(0, 4)));
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.opcode = '0; bus.op = '0; bus.cond = '0;
      bus.Z = 0; bus.N = 0; bus.V = 0; bus.mem_ready = 0; bus.resume = 0;
      #1;
      test_reset();
      test_alu();
      test_mov();
      test_mem();
      test_branch();
      test_halt();
      test_wait_limit();
      test_reset_mid_mwr();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
